// File: rtl/ifq_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entry layout: one cache line plus the PC of its first word.
package ifq_pkg;

    localparam int XLEN           = 32;
    localparam int LINE_W         = 128;
    localparam int INSTS_PER_LINE = 4;
    localparam int OFS_W          = 2;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [LINE_W-1:0] line;
        logic [XLEN-1:0]   base_pc;
    } ifq_entry_t;

    function automatic logic [XLEN-1:0] line_base(
        input logic [XLEN-1:0] pc
    );
        return {pc[XLEN-1:4], 4'b0000};
    endfunction

endpackage

// File: rtl/ifq_line_fifo.sv
// Circular storage of fetched lines for the instruction fetch queue.
// Flush clears pointers and occupancy; entry contents are left stale.
module ifq_line_fifo import ifq_pkg::*; #(
    parameter int                DEPTH    = 4,
    parameter logic [XLEN-1:0]   RST_BASE = RESET_PC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    wr_en,
    input  ifq_entry_t              wr_data,
    input  logic                    rd_en,
    output ifq_entry_t              head,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ifq_entry_t      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '{line: '0, base_pc: RST_BASE};
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(wr_en) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch queue between the I-cache and dispatch: line fetch, word select, redirect.
// Define IFQ_STATS_EN to add empty_cycles / flush_count statistics outputs.
module instr_fetch_queue #(
    parameter int               DEPTH    = 4,
    parameter int               XLEN     = 32,
    parameter int               LINE_W   = 128,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    output logic              icache_rd_en,
    output logic [XLEN-1:0]   icache_addr,
    input  logic [LINE_W-1:0] icache_line,
    input  logic              icache_valid,
    output logic [XLEN-1:0]   inst_out,
    output logic [XLEN-1:0]   pc_out,
    output logic              empty,
`ifdef IFQ_STATS_EN
    output logic [31:0]       empty_cycles,
    output logic [15:0]       flush_count,
`endif
    input  logic              rd_en,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc
);

    import ifq_pkg::*;

    logic                    run;
    logic                    inflight;
    logic [XLEN-1:0]         fetch_pc;
    logic [XLEN-1:0]         req_pc;
    logic [OFS_W-1:0]        word_ofs;
    logic [$clog2(DEPTH):0]  count;
    ifq_entry_t              head;
    ifq_entry_t              wr_data;
    logic                    issue;
    logic                    fill;
    logic                    pop;
    logic                    free;
    logic                    unused_pc_lsb;

    assign unused_pc_lsb = ^redirect_pc[1:0];

    // Slot is reserved at issue, so a returning line always has room.
    assign issue = run && !redirect_valid
                && (int'(count) + int'(inflight)) < DEPTH;

    // Response latency is fixed at one cycle, so an in-flight line
    // arrives in the redirect cycle itself and is dropped there.
    assign fill = icache_valid && inflight && !redirect_valid;
    assign pop  = rd_en && !empty && !redirect_valid;
    assign free = pop && (word_ofs == OFS_W'(INSTS_PER_LINE - 1));

    assign wr_data = '{line: icache_line, base_pc: req_pc};

    assign icache_rd_en = issue;
    assign icache_addr  = fetch_pc;

    assign empty    = (count == '0);
    assign inst_out = head.line[XLEN*int'(word_ofs) +: XLEN];
    assign pc_out   = head.base_pc + XLEN'({word_ofs, 2'b00});

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run      <= 1'b0;
            inflight <= 1'b0;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            word_ofs <= '0;
        end else begin
            run      <= 1'b1;
            inflight <= issue;
            if (redirect_valid) begin
                fetch_pc <= line_base(redirect_pc);
                word_ofs <= redirect_pc[3:2];
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + XLEN'(16);
                    req_pc   <= fetch_pc;
                end
                if (pop) begin
                    word_ofs <= word_ofs + 1'b1;
                end
            end
        end
    end

    ifq_line_fifo #(
        .DEPTH    (DEPTH),
        .RST_BASE (RESET_PC)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (redirect_valid),
        .wr_en   (fill),
        .wr_data (wr_data),
        .rd_en   (free),
        .head    (head),
        .count   (count)
    );

`ifdef IFQ_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            empty_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (empty) begin
                empty_cycles <= empty_cycles + 32'd1;
            end
            if (redirect_valid && flush_count != 16'hFFFF) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue against an instruction-stream model.
// Build with IFQ_STATS_EN defined to also check the statistics counters.
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         icache_rd_en;
    logic [31:0]  icache_addr;
    logic [127:0] icache_line;
    logic         icache_valid;
    logic [31:0]  inst_out;
    logic [31:0]  pc_out;
    logic         empty;
    logic         rd_en;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
`ifdef IFQ_STATS_EN
    logic [31:0]  empty_cycles;
    logic [15:0]  flush_count;
`endif

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_rd_en   (icache_rd_en),
        .icache_addr    (icache_addr),
        .icache_line    (icache_line),
        .icache_valid   (icache_valid),
        .inst_out       (inst_out),
        .pc_out         (pc_out),
        .empty          (empty),
`ifdef IFQ_STATS_EN
        .empty_cycles   (empty_cycles),
        .flush_count    (flush_count),
`endif
        .rd_en          (rd_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    int errors = 0;
    int checks = 0;

    // Model: PCs of instructions available to dispatch, in order.
    logic [31:0] mq[$];
    logic [31:0] popped[$];
    logic [31:0] m_fetch;
    logic [31:0] m_infl_addr;
    bit          m_run;
    bit          m_infl;
    int          m_skip;
    int          m_emptyc;
    int          m_flushes;
    // I-cache responder state.
    bit          pend;
    logic [31:0] pend_addr;
    bit          obs_empty;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0000_0013 + a;
    endfunction

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        logic [31:0]  b;
        b = {a[31:4], 4'b0000};
        for (int k = 0; k < 4; k++) begin
            l[32*k +: 32] = mem_word(b + 32'(4*k));
        end
        return l;
    endfunction

    function automatic int lines_held();
        int n = 0;
        for (int i = 0; i < mq.size(); i++) begin
            if (i == 0 || mq[i][31:4] != mq[i-1][31:4]) n++;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_fetch   = 32'h0;
        m_infl    = 1'b0;
        m_run     = 1'b0;
        m_skip    = 0;
        m_emptyc  = 0;
        m_flushes = 0;
        pend      = 1'b0;
        pend_addr = 32'h0;
    endtask

    task automatic reset_checks();
        chk("rst_empty", {31'b0, empty}, 32'd1);
        chk("rst_rd_en", {31'b0, icache_rd_en}, 32'd0);
        chk("rst_addr", icache_addr, 32'h0);
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_inst", inst_out, 32'h0);
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic cyc(input bit rd, input bit redir, input logic [31:0] rpc);
        bit          exp_rd;
        bit          exp_empty;
        logic [31:0] r;
        r              = $urandom();
        rd_en          = rd;
        redirect_valid = redir;
        redirect_pc    = rpc;
        icache_valid   = pend;
        icache_line    = pend ? line_of(pend_addr) : {4{r}};
        #1;
        exp_empty = (mq.size() == 0);
        exp_rd    = m_run && !redir && (lines_held() + int'(m_infl)) < DEPTH;
        chk("empty", {31'b0, empty}, {31'b0, exp_empty});
        chk("icache_rd_en", {31'b0, icache_rd_en}, {31'b0, exp_rd});
        if (exp_rd) chk("icache_addr", icache_addr, m_fetch);
        if (!exp_empty) begin
            chk("pc_out", pc_out, mq[0]);
            chk("inst_out", inst_out, mem_word(mq[0]));
        end
        obs_empty = empty;
        if (rd && !empty && !redir) popped.push_back(pc_out);
        if (exp_empty) m_emptyc++;
        if (redir) m_flushes++;
        pend      = icache_rd_en;
        pend_addr = icache_addr;
        if (redir) begin
            mq.delete();
            m_fetch = {rpc[31:4], 4'b0000};
            m_skip  = int'(rpc[3:2]);
            m_infl  = 1'b0;
        end else begin
            if (rd && mq.size() > 0) void'(mq.pop_front());
            if (icache_valid && m_infl) begin
                for (int k = m_skip; k < 4; k++) begin
                    mq.push_back(m_infl_addr + 32'(4*k));
                end
                m_skip = 0;
            end
            m_infl = exp_rd;
            if (exp_rd) begin
                m_infl_addr = m_fetch;
                m_fetch     = m_fetch + 32'd16;
            end
        end
        m_run = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int          first;
        int          nreq;
        int          tries;
        bit          rd;
        bit          redir;
        logic [31:0] rpc;

        rd_en          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        icache_valid   = 1'b0;
        icache_line    = '0;
        model_reset();
        #1;
        reset_checks();
        @(negedge clk);
        rst = 1'b1;

        // Stream from reset
        first = -1;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 1'b0, 32'h0);
            if (first < 0 && !obs_empty) first = i;
        end
        chk("first_valid", 32'(first), 32'd3);
        chk("stream_n", {31'b0, popped.size() >= 6}, 32'd1);
        if (popped.size() >= 6) begin
            chk("stream_pc0", popped[0], 32'h0);
            chk("stream_pc5", popped[5], 32'h14);
        end

        // Back-pressure after flush to an empty queue
        cyc(1'b0, 1'b1, 32'h200);
        nreq = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (pend) nreq++;
        end
        chk("bp_requests", 32'(nreq), 32'd4);
        popped.delete();
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 32'h0);
        chk("bp_pops", 32'(popped.size()), 32'd16);
        if (popped.size() == 16) begin
            chk("bp_first", popped[0], 32'h200);
            chk("bp_last", popped[15], 32'h23C);
        end

        // Mid-line redirect with a response in flight
        tries = 0;
        while (!pend && tries < 20) begin
            cyc(1'b1, 1'b0, 32'h0);
            tries++;
        end
        chk("mid_inflight", {31'b0, pend}, 32'd1);
        cyc(1'b1, 1'b1, 32'h108);
        popped.delete();
        cyc(1'b1, 1'b0, 32'h0);
        chk("mid_req", {31'b0, pend}, 32'd1);
        chk("mid_addr", pend_addr, 32'h100);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 32'h0);
        chk("mid_n", {31'b0, popped.size() >= 3}, 32'd1);
        if (popped.size() >= 3) begin
            chk("mid_pc0", popped[0], 32'h108);
            chk("mid_pc1", popped[1], 32'h10C);
            chk("mid_pc2", popped[2], 32'h110);
        end

        // Redirect coinciding with pop and fill
        tries = 0;
        while (!(pend && mq.size() > 0) && tries < 20) begin
            cyc(1'b1, 1'b0, 32'h0);
            tries++;
        end
        chk("coinc_setup", {31'b0, pend && mq.size() > 0}, 32'd1);
        cyc(1'b1, 1'b1, 32'h300);
        cyc(1'b1, 1'b0, 32'h0);
        chk("coinc_empty", {31'b0, obs_empty}, 32'd1);

        // PC wrap-around at the top of the address space
        cyc(1'b1, 1'b1, 32'hFFFF_FFE8);
        popped.delete();
        for (int i = 0; i < 20; i++) cyc(1'b1, 1'b0, 32'h0);
        chk("wrap_n", {31'b0, popped.size() >= 8}, 32'd1);
        if (popped.size() >= 8) chk("wrap_pc", popped[6], 32'h0000_0000);

        // Randomized traffic, including misaligned targets
        for (int i = 0; i < 400; i++) begin
            rd    = ($urandom_range(9) < 7);
            redir = ($urandom_range(24) == 0);
            rpc   = ($urandom_range(3) == 0) ?
                    (32'hFFFF_FFE0 | 32'($urandom_range(31))) : $urandom();
            cyc(rd, redir, rpc);
        end

`ifdef IFQ_STATS_EN
        chk("empty_cycles", empty_cycles, 32'(m_emptyc));
        chk("flush_count", {16'b0, flush_count}, 32'(m_flushes));
`endif

        // Asynchronous reset mid-stream
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 32'h0);
        @(posedge clk);
        #3;
        rst          = 1'b0;
        icache_valid = 1'b0;
        #1;
        reset_checks();
`ifdef IFQ_STATS_EN
        chk("rst_empty_cycles", empty_cycles, 32'd0);
        chk("rst_flush_count", {16'b0, flush_count}, 32'd0);
`endif
        model_reset();
        popped.delete();
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, 32'h0);
        chk("post_rst_n", {31'b0, popped.size() >= 2}, 32'd1);
        if (popped.size() >= 2) begin
            chk("post_rst_pc0", popped[0], 32'h0);
            chk("post_rst_pc1", popped[1], 32'h4);
        end

`ifdef IFQ_STATS_EN
        cyc(1'b1, 1'b1, 32'h40);
        cyc(1'b0, 1'b1, 32'h80);
        cyc(1'b1, 1'b0, 32'h0);
        chk("end_empty_cycles", empty_cycles, 32'(m_emptyc));
        chk("end_flush_count", {16'b0, flush_count}, 32'(m_flushes));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
